// File: rtl/blc_line_seq.sv
// Line sequencer for the 3x3-median black-level-correction path: tracks pixel
// position, strobes black/active windows, runs the reference divide, drains the line buffer.
module blc_line_seq #(
  parameter int BPS_L      = 1,
  parameter int BPN_L      = 100,
  parameter int READ_PIXEL = 16,
  parameter int BPN_R      = 100,
  parameter int CALC_TMO   = 64,
  parameter int LINE_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              blk_win,
  output logic              act_win,
  output logic              blk_trip,
  output logic              calc_start,
  input  logic              calc_done,
  output logic              rd_en,
  output logic              rd_last,
  input  logic              dn_ready,
  output logic              acc_clr,
  output logic              line_done,
  output logic [LINE_W-1:0] line_cnt,
  output logic              tmo_err,
  output logic [1:0]        fsm_state
);

  // Handshake: a pixel transfers on any cycle where in_valid & in_ready; in_valid
  // may drop at will, in_ready is high exactly while the sequencer is in RX.

  localparam int LINE_LEN = BPS_L + BPN_L + READ_PIXEL + BPN_R;
  localparam int PW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int TW = (CALC_TMO > 1) ? $clog2(CALC_TMO) : 1;
  localparam int DW = (READ_PIXEL > 1) ? $clog2(READ_PIXEL) : 1;

  localparam logic [PW-1:0] BLK0_START = PW'(BPS_L);
  localparam logic [PW-1:0] ACT_START  = PW'(BPS_L + BPN_L);
  localparam logic [PW-1:0] BLK1_START = PW'(BPS_L + BPN_L + READ_PIXEL);
  localparam logic [PW-1:0] PIX_LAST   = PW'(LINE_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(CALC_TMO - 1);
  localparam logic [DW-1:0] DRN_LAST   = DW'(READ_PIXEL - 1);

  typedef enum logic [1:0] {
    RX    = 2'd0,
    CALC  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   pix_cnt;
  logic [1:0]      blk_ph;
  logic [TW-1:0]   timer;
  logic [DW-1:0]   drn_cnt;
  logic            accept;

  assign fsm_state = state;
  assign in_ready  = (state == RX);
  assign accept    = in_valid & in_ready;

  // Pixel positions at or beyond the line end never occur, so the right black
  // window needs only its lower bound.
  assign blk_win  = accept & (((pix_cnt >= BLK0_START) && (pix_cnt < ACT_START)) ||
                              (pix_cnt >= BLK1_START));
  assign act_win  = accept & (pix_cnt >= ACT_START) & (pix_cnt < BLK1_START);
  assign blk_trip = blk_win & (blk_ph == 2'd2);

  assign rd_en   = (state == DRAIN) & dn_ready;
  assign rd_last = rd_en & (drn_cnt == DRN_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RX;
      pix_cnt    <= '0;
      blk_ph     <= '0;
      timer      <= '0;
      drn_cnt    <= '0;
      line_cnt   <= '0;
      tmo_err    <= 1'b0;
      calc_start <= 1'b0;
      acc_clr    <= 1'b0;
      line_done  <= 1'b0;
    end else begin
      calc_start <= 1'b0;
      acc_clr    <= 1'b0;
      line_done  <= 1'b0;
      case (state)
        RX: begin
          if (accept) begin
            if (blk_win) begin
              blk_ph <= (blk_ph == 2'd2) ? 2'd0 : blk_ph + 2'd1;
            end
            // End of line: leftover partial triplet is dropped by clearing the phase.
            if (pix_cnt == PIX_LAST) begin
              pix_cnt    <= '0;
              blk_ph     <= '0;
              timer      <= '0;
              calc_start <= 1'b1;
              state      <= CALC;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end
        CALC: begin
          if (calc_done) begin
            drn_cnt <= '0;
            state   <= DRAIN;
          end else if (timer == TMO_LAST) begin
            drn_cnt <= '0;
            tmo_err <= 1'b1;
            state   <= DRAIN;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DRAIN: begin
          if (rd_en) begin
            if (rd_last) begin
              drn_cnt   <= '0;
              line_done <= 1'b1;
              acc_clr   <= 1'b1;
              line_cnt  <= line_cnt + 1'b1;
              state     <= RX;
            end else begin
              drn_cnt <= drn_cnt + 1'b1;
            end
          end
        end
        default: state <= RX;
      endcase
    end
  end

endmodule

// File: tb/tb_blc_line_seq.sv
// Self-checking bench for blc_line_seq: table of whole-line scenarios plus a
// hand-written mid-line reset sequence; per-pixel window flags go through a scoreboard queue.
module tb_blc_line_seq;

  localparam int LINE_LEN = 217;
  localparam int N_RD     = 16;
  localparam int TMO      = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        blk_win;
  logic        act_win;
  logic        blk_trip;
  logic        calc_start;
  logic        calc_done = 1'b0;
  logic        rd_en;
  logic        rd_last;
  logic        dn_ready = 1'b0;
  logic        acc_clr;
  logic        line_done;
  logic [15:0] line_cnt;
  logic        tmo_err;
  logic [1:0]  fsm_state;

  blc_line_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .blk_win(blk_win), .act_win(act_win), .blk_trip(blk_trip),
    .calc_start(calc_start), .calc_done(calc_done), .rd_en(rd_en),
    .rd_last(rd_last), .dn_ready(dn_ready), .acc_clr(acc_clr),
    .line_done(line_done), .line_cnt(line_cnt), .tmo_err(tmo_err),
    .fsm_state(fsm_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          gap_pct;
    int          calc_dly;   // -1: never answer, forces the timeout
    int          dn_mode;    // 0 always ready, 1 toggling, 2 random
    logic        stray;      // random calc_done pulses while receiving
    logic        exp_tmo;
    logic [15:0] exp_lines;
  } line_row_t;

  line_row_t  rows[7];
  logic [2:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int model_p = 0;
  int model_ph = 0;
  int n_blk, n_act, n_trip;
  logic cur_tmo = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One receive cycle: expected window flags come from an independent position model.
  task automatic rx_step(input logic v, input logic cd);
    logic eb, ea, et;
    logic [2:0] got, want;
    in_valid  = v;
    calc_done = cd;
    if (v) begin
      eb = ((model_p >= 1) && (model_p < 101)) || ((model_p >= 117) && (model_p < LINE_LEN));
      ea = (model_p >= 101) && (model_p < 117);
      et = eb && (model_ph == 2);
      exp_q.push_back({eb, ea, et});
      if (eb) model_ph = (model_ph + 1) % 3;
      model_p++;
      if (model_p == LINE_LEN) begin
        model_p  = 0;
        model_ph = 0;
      end
    end
    @(negedge clk);
    check("rx_in_ready", in_ready, 1);
    check("rx_calc_start", calc_start, 0);
    got = {blk_win, act_win, blk_trip};
    if (v && exp_q.size() > 0) want = exp_q.pop_front();
    else want = 3'b000;
    check("rx_flags", got, want);
    n_blk  += blk_win;
    n_act  += act_win;
    n_trip += blk_trip;
    tick();
  endtask

  task automatic run_line(input line_row_t r);
    int acc, step, lim, pops;
    logic dn;
    n_blk = 0; n_act = 0; n_trip = 0;
    acc = 0; step = 0;
    while (acc < LINE_LEN && step < 5000) begin
      logic v;
      v = (r.gap_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= r.gap_pct);
      rx_step(v, r.stray && ($urandom_range(0, 7) == 0));
      if (v) acc++;
      step++;
    end
    check("rx_budget", (acc == LINE_LEN), 1);
    check("cnt_blk", n_blk, 200);
    check("cnt_act", n_act, 16);
    check("cnt_trip", n_trip, 66);

    in_valid = 1'b0;
    lim = (r.calc_dly < 0) ? TMO : r.calc_dly + 1;
    for (int k = 0; k < lim; k++) begin
      calc_done = (r.calc_dly >= 0) && (k == r.calc_dly);
      dn_ready  = 1'b1;
      @(negedge clk);
      check("calc_start", calc_start, (k == 0));
      check("calc_in_ready", in_ready, 0);
      check("calc_rd_en", rd_en, 0);
      check("calc_tmo_err", tmo_err, cur_tmo);
      tick();
    end
    calc_done = 1'b0;
    if (r.calc_dly < 0) cur_tmo = 1'b1;

    pops = 0; step = 0;
    while (pops < N_RD && step < 200) begin
      case (r.dn_mode)
        0: dn = 1'b1;
        1: dn = (step % 2 == 0);
        default: dn = 1'($urandom_range(0, 1));
      endcase
      dn_ready = dn;
      @(negedge clk);
      check("drn_rd_en", rd_en, dn);
      check("drn_in_ready", in_ready, 0);
      check("drn_line_done", line_done, 0);
      check("drn_tmo_err", tmo_err, cur_tmo);
      if (dn) pops++;
      check("drn_rd_last", rd_last, dn && (pops == N_RD));
      tick();
      step++;
    end
    check("drn_budget", pops, N_RD);

    dn_ready = 1'b0;
    @(negedge clk);
    check("ld_line_done", line_done, 1);
    check("ld_acc_clr", acc_clr, 1);
    check("ld_in_ready", in_ready, 1);
    check("ld_rd_en", rd_en, 0);
    check("ld_line_cnt", line_cnt, r.exp_lines);
    check("ld_tmo_err", tmo_err, r.exp_tmo);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; calc_done = 1'b0; dn_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_pulses", {calc_start, acc_clr, line_done, rd_en, rd_last}, 0);
    check("rst_line_cnt", line_cnt, 0);
    check("rst_tmo_err", tmo_err, 0);
    tick();
    rst = 1'b0;
    model_p = 0; model_ph = 0; cur_tmo = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    rows[0] = '{0,  5, 0, 1'b0, 1'b0, 16'd1};
    rows[1] = '{0,  5, 1, 1'b0, 1'b0, 16'd2};
    rows[2] = '{0, -1, 0, 1'b0, 1'b1, 16'd3};
    rows[3] = '{0,  2, 2, 1'b0, 1'b1, 16'd4};
    rows[4] = '{50, 3, 2, 1'b1, 1'b0, 16'd1};
    rows[5] = '{50, 0, 1, 1'b1, 1'b0, 16'd2};
    rows[6] = '{50, 7, 0, 1'b1, 1'b0, 16'd3};

    do_reset();
    for (int i = 0; i < 4; i++) run_line(rows[i]);

    // Clear sticky error, then abort a line at pixel 50 with a reset.
    do_reset();
    for (int i = 0; i < 50; i++) rx_step(1'b1, 1'b0);
    rst = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    model_p = 0; model_ph = 0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mrst_acc_clr", acc_clr, 0);
      check("mrst_line_done", line_done, 0);
      check("mrst_line_cnt", line_cnt, 0);
      check("mrst_in_ready", in_ready, 1);
      tick();
    end

    for (int i = 4; i < 7; i++) run_line(rows[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
